// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } clkdiv_mode_t;

    // A divisor of zero has no meaningful period, so it behaves as divide-by-one.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/staged settings, registered clk_out/tick.
// Outputs change one edge after a wrap; staged config waits for the next period boundary.
module clkdiv_channel #(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_mode,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 pending
);
    import clkdiv_pkg::*;

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] act_div;
    logic [DIV_WIDTH-1:0] stg_div;
    clkdiv_mode_t         act_mode;
    clkdiv_mode_t         stg_mode;
    logic                 wrap;
    logic [DIV_WIDTH-1:0] stg_clamped;
    logic [DIV_WIDTH-1:0] cfg_clamped;

    assign wrap        = (cnt == act_div - DIV_WIDTH'(1));
    assign stg_clamped = DIV_WIDTH'(clamp_div(32'(stg_div)));
    assign cfg_clamped = DIV_WIDTH'(clamp_div(32'(cfg_div)));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            act_div  <= DIV_WIDTH'(DEFAULT_DIV);
            act_mode <= MODE_TOGGLE;
            stg_div  <= '0;
            stg_mode <= MODE_TOGGLE;
            pending  <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else if (!en) begin
            // Idle channel: no boundary to wait for, so settings land immediately.
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (load) begin
                act_div  <= cfg_clamped;
                act_mode <= clkdiv_mode_t'(cfg_mode);
            end else if (pending) begin
                act_div  <= stg_clamped;
                act_mode <= stg_mode;
            end
        end else begin
            if (load) begin
                stg_div  <= cfg_div;
                stg_mode <= clkdiv_mode_t'(cfg_mode);
                pending  <= 1'b1;
            end
            if (wrap) begin
                cnt <= '0;
                if (pending && (stg_mode != act_mode)) begin
                    clk_out <= 1'b0;
                    tick    <= 1'b0;
                end else if (act_mode == MODE_PULSE) begin
                    clk_out <= 1'b1;
                    tick    <= 1'b1;
                end else begin
                    clk_out <= ~clk_out;
                    tick    <= ~clk_out;
                end
                if (pending) begin
                    act_div  <= stg_clamped;
                    act_mode <= stg_mode;
                    pending  <= 1'b0;
                end
            end else begin
                cnt  <= cnt + DIV_WIDTH'(1);
                tick <= 1'b0;
                if (act_mode == MODE_PULSE) begin
                    clk_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock/tick divider with a single valid/ready config port.
// Outputs registered; cfg_ready is combinational and low while the target channel has a staged update.
module clock_divider_multi #(
    parameter int N_CH        = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         en,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [DIV_WIDTH-1:0]    cfg_div,
    input  logic                    cfg_mode,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         pending
);
    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0] load;

    // Out-of-range channel numbers match nothing: always ready, silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        load      = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_ch == CH_W'(c)) begin
                cfg_ready = !pending[c];
                load[c]   = cfg_valid && !pending[c];
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        clkdiv_channel #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_in   (clk_in),
            .reset_n  (reset_n),
            .en       (en[c]),
            .load     (load[c]),
            .cfg_div  (cfg_div),
            .cfg_mode (cfg_mode),
            .clk_out  (clk_out[c]),
            .tick     (tick[c]),
            .pending  (pending[c])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi; expected values queued at drive time, popped after each edge.
module tb_clock_divider_multi;
    localparam int N_CH = 4;
    localparam int DW   = 16;
    localparam int DEF  = 3;

    logic          clk_in = 1'b0;
    logic          reset_n = 1'b0;
    logic [3:0]    en = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_ch = '0;
    logic [DW-1:0] cfg_div = '0;
    logic          cfg_mode = 1'b0;
    logic [3:0]    clk_out;
    logic [3:0]    tick;
    logic [3:0]    pending;

    clock_divider_multi #(
        .N_CH        (N_CH),
        .DIV_WIDTH   (DW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%0h required=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_cfg(input logic [1:0] ch, input logic [DW-1:0] d, input logic m);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = d;
        cfg_mode  = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        push("rst_clk", 4'b0000);  pop_cmp(clk_out);
        push("rst_tick", 4'b0000); pop_cmp(tick);
        push("rst_pend", 4'b0000); pop_cmp(pending);
        push("rst_rdy", 1'b1);     pop_cmp(cfg_ready);
        step();
        step();
        reset_n = 1'b1;
        en      = 4'b1111;

        // Default divisor 3, toggle: 3 high / 3 low, tick on rising edge
        for (int j = 1; j <= 18; j++) begin
            push($sformatf("t1_clk0_j%0d", j), ((j / 3) % 2) == 1);
            push($sformatf("t1_tick0_j%0d", j), (j % 6) == 3);
            step();
            pop_cmp(clk_out[0]);
            pop_cmp(tick[0]);
        end

        // ch1 loaded while disabled: D=4 pulse, never pending
        en[1] = 1'b0;
        drive_cfg(2'd1, 16'd4, 1'b1);
        push("t2_rdy", 1'b1); pop_cmp(cfg_ready);
        step();
        cfg_valid = 1'b0;
        push("t2_pend_load", 1'b0); pop_cmp(pending[1]);
        push("t2_clk_off", 1'b0);   pop_cmp(clk_out[1]);
        en[1] = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            push($sformatf("t2_tick1_j%0d", j), (j % 4) == 0);
            push($sformatf("t2_clk1_j%0d", j), (j % 4) == 0);
            push($sformatf("t2_pend1_j%0d", j), 1'b0);
            step();
            pop_cmp(tick[1]);
            pop_cmp(clk_out[1]);
            pop_cmp(pending[1]);
        end

        // ch0 D=5 toggle, then mid-period change to D=2
        en[0] = 1'b0;
        drive_cfg(2'd0, 16'd5, 1'b0);
        step();
        cfg_valid = 1'b0;
        push("t3_clk_off", 1'b0); pop_cmp(clk_out[0]);
        push("t3_pend_off", 1'b0); pop_cmp(pending[0]);
        en[0] = 1'b1;
        for (int j = 1; j <= 22; j++) begin
            if (j == 8) begin
                drive_cfg(2'd0, 16'd2, 1'b0);
                push("t3_rdy_pre", 1'b1); pop_cmp(cfg_ready);
            end
            if (j == 9) cfg_valid = 1'b0;
            if (j < 10) begin
                push($sformatf("t3_clk0_j%0d", j), j >= 5);
                push($sformatf("t3_tick0_j%0d", j), j == 5);
            end else begin
                push($sformatf("t3_clk0_j%0d", j), (((j - 10) / 2) % 2) == 1);
                push($sformatf("t3_tick0_j%0d", j), ((j - 10) % 4) == 2);
            end
            push($sformatf("t3_pend0_j%0d", j), (j == 8) || (j == 9));
            push($sformatf("t3_rdy0_j%0d", j), !((j == 8) || (j == 9)));
            step();
            pop_cmp(clk_out[0]);
            pop_cmp(tick[0]);
            pop_cmp(pending[0]);
            pop_cmp(cfg_ready);
        end

        // ch2 D=0 pulse clamps to 1: tick held high
        en[2] = 1'b0;
        drive_cfg(2'd2, 16'd0, 1'b1);
        step();
        cfg_valid = 1'b0;
        push("t4_tick_off", 1'b0); pop_cmp(tick[2]);
        en[2] = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            push($sformatf("t4_tick2_j%0d", j), 1'b1);
            push($sformatf("t4_clk2_j%0d", j), 1'b1);
            step();
            pop_cmp(tick[2]);
            pop_cmp(clk_out[2]);
        end

        // ch3: enable dropped while pending applies staged D=6 pulse
        en[3] = 1'b0;
        step();
        en[3] = 1'b1;
        step();
        drive_cfg(2'd3, 16'd6, 1'b1);
        push("t5_rdy", 1'b1); pop_cmp(cfg_ready);
        step();
        cfg_valid = 1'b0;
        push("t5_pend_set", 1'b1); pop_cmp(pending[3]);
        en[3] = 1'b0;
        step();
        push("t5_clk_drop", 1'b0);  pop_cmp(clk_out[3]);
        push("t5_tick_drop", 1'b0); pop_cmp(tick[3]);
        push("t5_pend_drop", 1'b0); pop_cmp(pending[3]);
        en[3] = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            if (j == 14) drive_cfg(2'd3, 16'd2, 1'b0);
            if (j == 15) cfg_valid = 1'b0;
            if (j < 18) begin
                push($sformatf("t5_tick3_j%0d", j), (j % 6) == 0);
                push($sformatf("t5_clk3_j%0d", j), (j % 6) == 0);
            end else begin
                push($sformatf("t5_tick3_j%0d", j), ((j - 18) % 4) == 2);
                push($sformatf("t5_clk3_j%0d", j), (((j - 18) / 2) % 2) == 1);
            end
            push($sformatf("t5_pend3_j%0d", j), (j >= 14) && (j <= 17));
            step();
            pop_cmp(tick[3]);
            pop_cmp(clk_out[3]);
            pop_cmp(pending[3]);
        end

        // Asynchronous reset mid-period
        step();
        push("t6_tick2_pre", 1'b1); pop_cmp(tick[2]);
        #3;
        reset_n = 1'b0;
        #1;
        push("t6_clk_rst", 4'b0000);  pop_cmp(clk_out);
        push("t6_tick_rst", 4'b0000); pop_cmp(tick);
        push("t6_pend_rst", 4'b0000); pop_cmp(pending);
        #10;
        step();
        reset_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            push($sformatf("t6_clk_j%0d", j), {4{((j / 3) % 2) == 1}});
            push($sformatf("t6_tick_j%0d", j), {4{(j % 6) == 3}});
            push($sformatf("t6_pend_j%0d", j), 4'b0000);
            step();
            pop_cmp(clk_out);
            pop_cmp(tick);
            pop_cmp(pending);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
